cordic_iterative: RTL and testbench
===================================

# cordic_iterative

Folded CORDIC engine that reuses one shift-add datapath over `ITERATIONS` clock cycles. It replaces a fully unrolled stage chain where area matters more than throughput. It supports rotation and vectoring mode over the full circle by adding a ±π/2 quadrant pre-rotation. Operands enter and results leave through valid/ready handshakes, so it sits between any upstream angle/vector source and downstream consumer.

## Interface
- `XY_WIDTH`, 16, signed width of input x/y.
- `ANGLE_WIDTH`, 16, signed angle width. The range −2^(AW−1)..2^(AW−1)−1 maps to [−π, π), so π/2 = 2^(AW−2).
- `ITERATIONS`, 14, number of micro-rotations. Legal range is 2..min(32, ANGLE_WIDTH).

Ports:
- `clk`, in, 1, clock. All state changes on the rising edge.
- `reset`, in, 1, asynchronous, active-high reset.
- `in_valid`, in, 1, operand valid.
- `in_ready`, out, 1, engine can accept an operand this cycle.
- `in_mode`, in, 1, 0 = rotation, 1 = vectoring.
- `in_x`, in, XY_WIDTH, signed x.
- `in_y`, in, XY_WIDTH, signed y.
- `in_z`, in, ANGLE_WIDTH, signed angle. In rotation mode it is the target angle; in vectoring mode it is an offset added to the result.
- `out_valid`, out, 1, result valid. Held until accepted.
- `out_ready`, in, 1, consumer accepts the result.
- `out_mode`, out, 1, mode of the result.
- `out_x`, out, XY_WIDTH+2, signed x result.
- `out_y`, out, XY_WIDTH+2, signed y result.
- `out_z`, out, ANGLE_WIDTH, signed angle result.

## Operation
- **State machine:** IDLE → PRE → ITER → DONE.
- **Accept:** an operand is accepted when `in_valid & in_ready`.
  - `in_ready = (state==IDLE) | (state==DONE & out_ready)`.
- **On accept:**
  - Latch the mode.
  - Sign-extend x and y to W = XY_WIDTH+2.
  - Latch z.
  - Go to PRE.
- **PRE (one cycle), rotation mode:**
  - z[AW−1:AW−2]==01 (z ≥ π/2): x←−y, y←x, z←z−π/2.
  - z[AW−1:AW−2]==10 (z < −π/2): x←y, y←−x, z←z+π/2.
  - Otherwise no change.
- **PRE (one cycle), vectoring mode:**
  - x<0 and y≥0: x←y, y←−x, z←z+π/2.
  - x<0 and y<0: x←−y, y←x, z←z−π/2.
  - Otherwise no change.
- **After PRE:** clear iteration counter i to 0 and go to ITER.
- **ITER, per cycle:**
  - Direction d = +1 when (rotation: z≥0) or (vectoring: y<0); otherwise d = −1.
  - x←x − d·(y>>>i).
  - y←y + d·(x>>>i). Use old x/y on both right-hand sides.
  - z←z − d·A[i].
  - i←i+1.
  - After i = ITERATIONS−1, go to DONE.
- **Arctan table:** A[i] = round(atan(2^−i)·2^(AW−1)/π). It is an elaboration-time constant table of ITERATIONS entries. A[0] = 2^(AW−3).
- **Arithmetic:**
  - Shifts are arithmetic, with a variable shift amount.
  - Angle arithmetic is modular in ANGLE_WIDTH; wrap-around is intended.
  - x/y need no saturation: the 2 guard bits cover gain K·√2 < 4.
  - Negation of −2^(XY_WIDTH−1) is exact in W bits.
- **No gain compensation.** Rotation results are scaled by K ≈ 1.6468. Vectoring magnitude in out_x is K·√(x²+y²).
- **DONE:**
  - `out_valid=1`; outputs are driven from the working registers and are stable.
  - If `out_ready` is high and `in_valid` is high: accept the new operand in the same cycle and go to PRE.
  - If `out_ready` is high and `in_valid` is low: go to IDLE.
  - If `out_ready` is low: hold.
- **Ignored inputs:** `in_*` are ignored outside accept cycles.

## Timing
- **Reset (asynchronous):**
  - state=IDLE, i=0.
  - `out_valid`=0, `out_mode`=0, `out_x`=`out_y`=`out_z`=0.
  - `in_ready`=1 right after reset deassertion.
- **Latency:** `out_valid` rises ITERATIONS+2 rising edges after the accept edge (14 iterations → 16).
- **Throughput:** one result per ITERATIONS+2 cycles with `out_ready` held high, because a new operand is accepted on the DONE/accept edge.
- **`in_ready`:** low throughout PRE and ITER.
- **Back-pressure:** `out_valid` and result values do not change while `out_valid & ~out_ready`.
- **Reset mid-operation:** discards the operation immediately. No partial result is ever presented.
- **Combinational path:** `in_ready` depends combinationally on `out_ready`. There is no other input→output combinational path.

## Test plan
- **Rotation, z=0:** AW=16, x=10000, y=0, z=0 → out_x ≈ 16468 ±4, out_y ≈ 0 ±4, out_z ≈ 0 ±ITERATIONS; `out_valid` at edge 16.
- **Vectoring, x=y:** x=y=8000, z=0 → out_z ≈ 8192 (π/4) ±4, out_x ≈ 18632 ±6, out_y ≈ 0 ±4.
- **Pre-rotation:**
  - Rotation with x=10000, y=0, z=−32768 (−π) → out_x ≈ −16468.
  - Vectoring with x=−8000, y=−8000 → out_z ≈ −24576 (−3π/4).
- **Back-pressure and back-to-back:**
  - Hold `out_ready`=0 for 5 cycles in DONE → outputs stable, `in_ready`=0.
  - Raise `out_ready` with `in_valid` high → second operand accepted that edge; its result appears 16 edges later.
- **Reset mid-operation:** assert `reset` during ITER with i=5 → all outputs 0 at once, `out_valid` never pulses. A following operand completes with correct latency.
- **Extremes:** x=y=−32768 and x=32767, y=−32768 in both modes → no overflow; results match the reference model within ±(ITERATIONS/2+2) LSB.

Source files
------------

// File: rtl/cordic_iterative.sv
// ---------------------------------------------------------------------------
// cordic_iterative
//
// Folded CORDIC engine: one shift-add datapath is reused for ITERATIONS
// clock cycles per operand. Supports rotation (mode 0) and vectoring
// (mode 1) over the full circle by applying a +/-pi/2 quadrant
// pre-rotation before the micro-rotations. No gain compensation is applied,
// so x/y results carry the CORDIC gain K ~= 1.6468.
//
// Angle encoding: ANGLE_WIDTH-bit two's complement, full scale = [-pi, pi),
// so pi/2 = 2^(ANGLE_WIDTH-2). Angle arithmetic wraps modulo 2^ANGLE_WIDTH.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready operand handshake (in_ready also follows out_ready
//                     combinationally while a result is being handed off)
//   in_mode           0 = rotation, 1 = vectoring
//   in_x, in_y        signed XY_WIDTH operand
//   in_z              signed angle (target in rotation, offset in vectoring)
//   out_valid/out_ready result handshake; result held until accepted
//   out_mode          mode of the presented result
//   out_x, out_y      signed XY_WIDTH+2 results (2 guard bits for gain)
//   out_z             signed ANGLE_WIDTH angle result
//
// Timing: with the accept edge counted as edge 1, out_valid is high after
// edge ITERATIONS+2 (one PRE cycle, ITERATIONS ITER cycles). A new operand
// can be accepted on the same edge that hands off a result, giving one
// result per ITERATIONS+2 cycles.
// ---------------------------------------------------------------------------
module cordic_iterative #(
  parameter int XY_WIDTH    = 16,
  parameter int ANGLE_WIDTH = 16,
  parameter int ITERATIONS  = 14
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_mode,
  input  logic signed [XY_WIDTH-1:0]    in_x,
  input  logic signed [XY_WIDTH-1:0]    in_y,
  input  logic signed [ANGLE_WIDTH-1:0] in_z,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_mode,
  output logic signed [XY_WIDTH+1:0]    out_x,
  output logic signed [XY_WIDTH+1:0]    out_y,
  output logic signed [ANGLE_WIDTH-1:0] out_z
);

  localparam int W  = XY_WIDTH + 2;
  localparam int AW = ANGLE_WIDTH;
  localparam int CW = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;

  // Scale shift from the 32-bit reference table down to AW bits.
  localparam int TSH = 32 - AW;

  localparam logic signed [AW-1:0] HALF_PI = AW'(1) << (AW - 2);
  localparam logic [CW-1:0]        LAST_I  = CW'(ITERATIONS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PRE  = 2'd1;
  localparam logic [1:0] S_ITER = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  if (ITERATIONS < 2 || ITERATIONS > 32 || ITERATIONS > ANGLE_WIDTH) begin : g_param_check
    $error("cordic_iterative: ITERATIONS must be in 2..min(32, ANGLE_WIDTH)");
  end

  // -------------------------------------------------------------------------
  // Arctangent table. Reference values are round(atan(2^-i) * 2^31 / pi),
  // i.e. the angle in a 32-bit full-circle encoding. Narrower angle widths
  // are derived by a rounded right shift; the reference carries enough
  // extra precision that this matches direct rounding at the target width.
  // -------------------------------------------------------------------------
  function automatic logic [AW-1:0] atan_entry(input int idx);
    logic [63:0] t;
    logic [63:0] r;
    case (idx)
      0:  t = 64'd536870912;
      1:  t = 64'd316933406;
      2:  t = 64'd167458907;
      3:  t = 64'd85004756;
      4:  t = 64'd42667331;
      5:  t = 64'd21354465;
      6:  t = 64'd10679838;
      7:  t = 64'd5340245;
      8:  t = 64'd2670163;
      9:  t = 64'd1335087;
      10: t = 64'd667544;
      11: t = 64'd333772;
      12: t = 64'd166886;
      13: t = 64'd83443;
      14: t = 64'd41722;
      15: t = 64'd20861;
      16: t = 64'd10430;
      17: t = 64'd5215;
      18: t = 64'd2608;
      19: t = 64'd1304;
      20: t = 64'd652;
      21: t = 64'd326;
      22: t = 64'd163;
      23: t = 64'd81;
      24: t = 64'd41;
      25: t = 64'd20;
      26: t = 64'd10;
      27: t = 64'd5;
      28: t = 64'd3;
      29: t = 64'd1;
      30: t = 64'd1;
      default: t = 64'd0;
    endcase
    if (TSH == 0) r = t;
    else          r = (t + (64'd1 << (TSH - 1))) >> TSH;
    return r[AW-1:0];
  endfunction

  logic signed [AW-1:0] atan_tab [ITERATIONS];

  for (genvar g = 0; g < ITERATIONS; g++) begin : g_atan
    assign atan_tab[g] = atan_entry(g);
  end

  // -------------------------------------------------------------------------
  // Working registers double as the result registers.
  // -------------------------------------------------------------------------
  logic [1:0]           state;
  logic [CW-1:0]        iter;
  logic                 mode_q;
  logic signed [W-1:0]  x_q;
  logic signed [W-1:0]  y_q;
  logic signed [AW-1:0] z_q;

  logic                 accept;
  logic                 dir_pos;
  logic signed [W-1:0]  x_sh;
  logic signed [W-1:0]  y_sh;
  logic signed [AW-1:0] atan_i;

  assign in_ready = (state == S_IDLE) | ((state == S_DONE) & out_ready);
  assign accept   = in_valid & in_ready;

  // d = +1: rotation drives z toward 0 from above; vectoring lifts y toward 0.
  assign dir_pos = mode_q ? y_q[W-1] : ~z_q[AW-1];
  assign x_sh    = x_q >>> iter;
  assign y_sh    = y_q >>> iter;
  assign atan_i  = atan_tab[iter];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      iter   <= '0;
      mode_q <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
    end else if (accept) begin
      // Only reachable from IDLE or from DONE while the result is consumed.
      mode_q <= in_mode;
      x_q    <= {{2{in_x[XY_WIDTH-1]}}, in_x};
      y_q    <= {{2{in_y[XY_WIDTH-1]}}, in_y};
      z_q    <= in_z;
      state  <= S_PRE;
    end else begin
      case (state)
        S_PRE: begin
          // Quadrant fold: bring the problem into the +/-pi/2 range the
          // micro-rotations can converge over.
          if (!mode_q) begin
            if (z_q[AW-1:AW-2] == 2'b01) begin
              x_q <= -y_q;
              y_q <= x_q;
              z_q <= z_q - HALF_PI;
            end else if (z_q[AW-1:AW-2] == 2'b10) begin
              x_q <= y_q;
              y_q <= -x_q;
              z_q <= z_q + HALF_PI;
            end
          end else if (x_q[W-1]) begin
            if (!y_q[W-1]) begin
              x_q <= y_q;
              y_q <= -x_q;
              z_q <= z_q + HALF_PI;
            end else begin
              x_q <= -y_q;
              y_q <= x_q;
              z_q <= z_q - HALF_PI;
            end
          end
          iter  <= '0;
          state <= S_ITER;
        end
        S_ITER: begin
          if (dir_pos) begin
            x_q <= x_q - y_sh;
            y_q <= y_q + x_sh;
            z_q <= z_q - atan_i;
          end else begin
            x_q <= x_q + y_sh;
            y_q <= y_q - x_sh;
            z_q <= z_q + atan_i;
          end
          // Counter stops on the last index so the table is never read
          // out of range.
          if (iter == LAST_I) state <= S_DONE;
          else                iter  <= iter + 1'b1;
        end
        S_DONE: begin
          // Accept-on-handoff is covered above; here the result was taken
          // with no new operand waiting.
          if (out_ready) state <= S_IDLE;
        end
        default: ;
      endcase
    end
  end

  assign out_valid = (state == S_DONE);
  assign out_mode  = mode_q;
  assign out_x     = x_q;
  assign out_y     = y_q;
  assign out_z     = z_q;

endmodule

// File: tb/tb_cordic_iterative.sv
// ---------------------------------------------------------------------------
// tb_cordic_iterative
//
// Directed plus randomized checks of cordic_iterative (16/16/14). Expected
// results come from a bit-exact reference of the algorithm (integer
// arithmetic, arctan table from $atan) and, for the directed cases, from the
// ideal trigonometric result with a tolerance. Latency is counted with the
// accept edge as edge 1; out_valid must first be seen after edge ITER+2.
// ---------------------------------------------------------------------------
module tb_cordic_iterative;

  localparam int XW  = 16;
  localparam int AW  = 16;
  localparam int IT  = 14;
  localparam int W   = XW + 2;
  localparam int LAT = IT + 2;
  localparam longint Q = longint'(1) << (AW - 2);
  localparam real PI = 3.14159265358979323846;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_mode;
  logic signed [XW-1:0] in_x;
  logic signed [XW-1:0] in_y;
  logic signed [AW-1:0] in_z;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_mode;
  logic signed [W-1:0]  out_x;
  logic signed [W-1:0]  out_y;
  logic signed [AW-1:0] out_z;

  cordic_iterative #(.XY_WIDTH(XW), .ANGLE_WIDTH(AW), .ITERATIONS(IT)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_x(in_x), .in_y(in_y), .in_z(in_z),
    .out_valid(out_valid), .out_ready(out_ready), .out_mode(out_mode),
    .out_x(out_x), .out_y(out_y), .out_z(out_z)
  );

  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  longint atab [IT];
  real    kgain;
  longint ex, ey, ez;
  bit     emode;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_near(input string tag, input real obs, input real exp, input real tol);
    real d;
    d = obs - exp;
    if (d < 0.0) d = -d;
    checks++;
    assert (d <= tol) else begin
      errors++;
      $error("FAIL %s observed=%0f expected=%0f tol=%0f", tag, obs, exp, tol);
    end
  endtask

  // Angle comparison modulo the full circle.
  task automatic chk_ang(input string tag, input real obs, input real exp, input real tol);
    real d;
    d = obs - exp;
    while (d >= 32768.0) d = d - 65536.0;
    while (d < -32768.0) d = d + 65536.0;
    chk_near(tag, exp + d, exp, tol);
  endtask

  function automatic longint wrapz(input longint v);
    longint m;
    longint r;
    m = longint'(1) << AW;
    r = v & (m - 1);
    if (r >= m / 2) r = r - m;
    return r;
  endfunction

  // Bit-exact reference: quadrant fold then ITER shift-add micro-rotations.
  task automatic model(input bit mode, input longint x0, input longint y0, input longint z0,
                       output longint ox, output longint oy, output longint oz);
    longint x, y, z, t;
    longint d;
    x = x0; y = y0; z = z0;
    if (!mode) begin
      if (z >= Q)       begin t = x; x = -y; y = t;  z = wrapz(z - Q); end
      else if (z < -Q)  begin t = x; x = y;  y = -t; z = wrapz(z + Q); end
    end else if (x < 0) begin
      if (y >= 0) begin t = x; x = y;  y = -t; z = wrapz(z + Q); end
      else        begin t = x; x = -y; y = t;  z = wrapz(z - Q); end
    end
    for (int i = 0; i < IT; i++) begin
      d = (mode ? (y < 0) : (z >= 0)) ? 1 : -1;
      t = x - d * (y >>> i);
      y = y + d * (x >>> i);
      x = t;
      z = wrapz(z - d * atab[i]);
    end
    ox = x; oy = y; oz = z;
  endtask

  task automatic issue(input bit mode, input longint x, input longint y, input longint z);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin tick(); n++; end
    chk("in_ready_at_accept", longint'(in_ready), 1);
    in_mode  = mode;
    in_x     = XW'(x);
    in_y     = XW'(y);
    in_z     = AW'(z);
    in_valid = 1'b1;
    emode    = mode;
    model(mode, longint'(in_x), longint'(in_y), longint'(in_z), ex, ey, ez);
    tick();
    // Junk on the inputs outside the accept cycle must be ignored.
    in_valid = 1'b0;
    in_mode  = ~mode;
    in_x     = XW'($urandom);
    in_y     = XW'($urandom);
    in_z     = AW'($urandom);
  endtask

  task automatic wait_result(input string tag);
    int e;
    e = 1;
    while (!out_valid && e < LAT + 40) begin tick(); e++; end
    chk({tag, "_latency"}, longint'(e), longint'(LAT));
    chk({tag, "_x"}, longint'(out_x), ex);
    chk({tag, "_y"}, longint'(out_y), ey);
    chk({tag, "_z"}, longint'(out_z), ez);
    chk({tag, "_mode"}, longint'(out_mode), longint'(emode));
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    tick();
    chk({tag, "_released"}, longint'(out_valid), 0);
  endtask

  task automatic ideal_rot(input string tag, input real x, input real y, input real z);
    real th;
    th = z * PI / 32768.0;
    chk_near({tag, "_ideal_x"}, real'(out_x), kgain * (x * $cos(th) - y * $sin(th)), 12.0);
    chk_near({tag, "_ideal_y"}, real'(out_y), kgain * (x * $sin(th) + y * $cos(th)), 12.0);
    chk_ang({tag, "_ideal_z"}, real'(out_z), 0.0, real'(IT));
  endtask

  task automatic ideal_vec(input string tag, input real x, input real y, input real z);
    chk_near({tag, "_ideal_x"}, real'(out_x), kgain * $sqrt(x * x + y * y), 12.0);
    chk_near({tag, "_ideal_y"}, real'(out_y), 0.0, 12.0);
    chk_ang({tag, "_ideal_z"}, real'(out_z), z + $atan2(y, x) * 32768.0 / PI, 8.0);
  endtask

  initial begin
    longint hx, hy, hz;
    int     pulses;
    int     hold;
    longint rx, ry, rz;
    bit     rm;

    kgain = 1.0;
    for (int i = 0; i < IT; i++) begin
      atab[i] = longint'($atan(2.0 ** (-i)) * 32768.0 / PI);
      kgain   = kgain * $sqrt(1.0 + 2.0 ** (-2 * i));
    end

    reset = 1'b1; in_valid = 1'b0; in_mode = 1'b0;
    in_x = '0; in_y = '0; in_z = '0; out_ready = 1'b1;
    tick(); tick();
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_mode", longint'(out_mode), 0);
    chk("rst_out_x", longint'(out_x), 0);
    chk("rst_out_y", longint'(out_y), 0);
    chk("rst_out_z", longint'(out_z), 0);
    reset = 1'b0;
    tick();
    chk("rst_in_ready", longint'(in_ready), 1);

    // Directed cases from the plan.
    issue(1'b0, 10000, 0, 0);
    wait_result("rot_z0");
    ideal_rot("rot_z0", 10000.0, 0.0, 0.0);
    release_result("rot_z0");

    issue(1'b1, 8000, 8000, 0);
    wait_result("vec_45");
    ideal_vec("vec_45", 8000.0, 8000.0, 0.0);
    release_result("vec_45");

    issue(1'b0, 10000, 0, -32768);
    wait_result("rot_mpi");
    ideal_rot("rot_mpi", 10000.0, 0.0, -32768.0);
    release_result("rot_mpi");

    issue(1'b1, -8000, -8000, 0);
    wait_result("vec_m135");
    ideal_vec("vec_m135", -8000.0, -8000.0, 0.0);
    release_result("vec_m135");

    // Extremes in both modes.
    issue(1'b0, -32768, -32768, 0);     wait_result("ext_rot_mm");  release_result("ext_rot_mm");
    issue(1'b1, -32768, -32768, 0);     wait_result("ext_vec_mm");  release_result("ext_vec_mm");
    issue(1'b0, 32767, -32768, 12345);  wait_result("ext_rot_pm");  release_result("ext_rot_pm");
    issue(1'b1, 32767, -32768, -20000); wait_result("ext_vec_pm");  release_result("ext_vec_pm");

    // Back-pressure for 5 cycles, then hand off straight into a new operand.
    out_ready = 1'b0;
    issue(1'b0, -12000, 9000, 20000);
    wait_result("bp");
    hx = longint'(out_x); hy = longint'(out_y); hz = longint'(out_z);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_valid_held", longint'(out_valid), 1);
      chk("bp_in_ready_low", longint'(in_ready), 0);
      chk("bp_x_stable", longint'(out_x), hx);
      chk("bp_y_stable", longint'(out_y), hy);
      chk("bp_z_stable", longint'(out_z), hz);
    end
    out_ready = 1'b1;
    #1;
    chk("b2b_in_ready_comb", longint'(in_ready), 1);
    issue(1'b1, 5000, -7000, 1000);
    chk("b2b_first_consumed", longint'(out_valid), 0);
    wait_result("b2b");
    release_result("b2b");

    // Reset during ITER at i = 5 (accept = edge 1, PRE->ITER at edge 2).
    issue(1'b0, 15000, -4000, 7000);
    repeat (6) tick();
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", longint'(out_valid), 0);
    chk("mid_rst_x", longint'(out_x), 0);
    chk("mid_rst_y", longint'(out_y), 0);
    chk("mid_rst_z", longint'(out_z), 0);
    chk("mid_rst_mode", longint'(out_mode), 0);
    tick(); tick();
    reset = 1'b0;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (out_valid) pulses++;
    end
    chk("mid_rst_no_pulse", longint'(pulses), 0);
    issue(1'b1, -3000, 11000, 0);
    wait_result("post_rst");
    release_result("post_rst");

    // Randomized operands with random back-pressure.
    for (int n = 0; n < 40; n++) begin
      rm = 1'($urandom_range(0, 1));
      rx = longint'($urandom_range(0, 65535)) - 32768;
      ry = longint'($urandom_range(0, 65535)) - 32768;
      rz = longint'($urandom_range(0, 65535)) - 32768;
      out_ready = 1'($urandom_range(0, 1));
      issue(rm, rx, ry, rz);
      wait_result("rand");
      if (!out_ready) begin
        hold = $urandom_range(1, 4);
        repeat (hold) tick();
        chk("rand_held", longint'(out_valid), 1);
        chk("rand_held_x", longint'(out_x), ex);
      end
      release_result("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
